// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : External-load controller for the CPU test harness. Accepts load
//            commands (select, base, count), streams words into one of
//            NUM_MEM memories at auto-incremented addresses, holds the CPU in
//            reset until run is requested, then passes CPU stores through to
//            the data memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_MEM   = 2,
  parameter int SEL_W     = 1,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int DMEM_IDX  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SEL_W-1:0]   cmd_sel,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               run,
  input  logic               halt,
  output logic               cpu_reset,
  input  logic               cpu_mem_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               load_done,
  output logic               load_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [ADDR_W-1:0]  r_addrPtr;
  logic [LEN_W-1:0]   r_remaining;
  logic [NUM_MEM-1:0] r_memWe;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [DATA_W-1:0]  r_memWdata;
  logic               r_loadDone;
  logic               r_loadErr;
  logic               r_cpuReset;

  logic               w_cmdFire;
  logic               w_wrFire;
  logic               w_cmdSelBad;
  logic [NUM_MEM-1:0] w_selOneHot;

  assign cmd_ready   = (r_state == S_IDLE);
  assign wr_ready    = (r_state == S_LOAD) && (r_remaining != '0);
  assign w_cmdFire   = cmd_valid && cmd_ready;
  assign w_wrFire    = wr_valid && wr_ready;
  assign w_cmdSelBad = (int'(cmd_sel) >= NUM_MEM);

  // An out-of-range latched select decodes to all zeros, so its words are
  // consumed without touching any memory.
  for (genvar i = 0; i < NUM_MEM; i++) begin : g_selDecode
    assign w_selOneHot[i] = (int'(r_sel) == i);
  end

  // Control FSM with registered write port, done pulse, error flag and CPU reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_addrPtr   <= '0;
      r_remaining <= '0;
      r_memWe     <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_loadDone  <= 1'b0;
      r_loadErr   <= 1'b0;
      r_cpuReset  <= 1'b1;
    end else begin
      r_memWe    <= '0;
      r_loadDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cpuReset <= 1'b1;
          if (w_cmdFire) begin
            r_sel       <= cmd_sel;
            r_addrPtr   <= cmd_base;
            r_remaining <= cmd_len;
            r_state     <= S_LOAD;
            if (w_cmdSelBad) r_loadErr <= 1'b1;
            // Empty command: the done pulse lands in the cycle after acceptance.
            if (cmd_len == '0) r_loadDone <= 1'b1;
          end else if (run) begin
            r_state    <= S_RUN;
            r_cpuReset <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_remaining == '0) begin
            r_state <= S_IDLE;
          end else if (w_wrFire) begin
            r_memWe     <= w_selOneHot;
            r_memAddr   <= r_addrPtr;
            r_memWdata  <= wr_data;
            r_addrPtr   <= r_addrPtr + ADDR_W'(ADDR_STEP);
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_loadDone <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state    <= S_IDLE;
            r_cpuReset <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory port: CPU store passthrough while running, loader registers otherwise.
  always_comb begin
    mem_we    = r_memWe;
    mem_addr  = r_memAddr;
    mem_wdata = r_memWdata;
    if (r_state == S_RUN) begin
      mem_we           = '0;
      mem_we[DMEM_IDX] = cpu_mem_we;
      mem_addr         = cpu_addr;
      mem_wdata        = cpu_wdata;
    end
  end

  assign cpu_reset = r_cpuReset;
  assign load_done = r_loadDone;
  assign load_err  = r_loadErr;
  assign busy      = (r_state == S_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Directed self-checking bench for mem_loader (NUM_MEM=2, SEL_W=2
//            so that an out-of-range select can be driven).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_sel;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        run;
  logic        halt;
  logic        cpu_reset;
  logic        cpu_mem_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        load_done;
  logic        load_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_loader #(
    .DATA_W(32), .ADDR_W(32), .NUM_MEM(2), .SEL_W(2),
    .LEN_W(16), .ADDR_STEP(4), .DMEM_IDX(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .run(run), .halt(halt), .cpu_reset(cpu_reset),
    .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (mem_we !== 2'b00) begin errors++; $display("FAIL rst_we got %b exp 00", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flags got done=%b err=%b busy=%b exp 0 0 0", load_done, load_err, busy); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got cmd=%b wr=%b exp 1 0", cmd_ready, wr_ready); end
  endtask

  task automatic test_load_imem;
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h0; cmd_len = 16'd3;
    tick();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || wr_ready !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL t1_load_state got busy=%b wr=%b cmd=%b exp 1 1 0", busy, wr_ready, cmd_ready); end
    wr_valid = 1'b1; wr_data = 32'hA1;
    tick();
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h0 || mem_wdata !== 32'hA1 || load_done !== 1'b0) begin errors++; $display("FAIL t1_w0 got we=%b a=%h d=%h done=%b exp 01 0 a1 0", mem_we, mem_addr, mem_wdata, load_done); end
    wr_data = 32'hB2;
    tick();
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h4 || mem_wdata !== 32'hB2 || load_done !== 1'b0) begin errors++; $display("FAIL t1_w1 got we=%b a=%h d=%h done=%b exp 01 4 b2 0", mem_we, mem_addr, mem_wdata, load_done); end
    wr_data = 32'hC3;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h8 || mem_wdata !== 32'hC3 || load_done !== 1'b1) begin errors++; $display("FAIL t1_w2 got we=%b a=%h d=%h done=%b exp 01 8 c3 1", mem_we, mem_addr, mem_wdata, load_done); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL t1_end_state got busy=%b cmd=%b cpu_reset=%b exp 0 1 1", busy, cmd_ready, cpu_reset); end
    tick();
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0) begin errors++; $display("FAIL t1_after got we=%b done=%b exp 00 0", mem_we, load_done); end
  endtask

  task automatic test_gapped_wrap;
    cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_base = 32'hFFFF_FFFC; cmd_len = 16'd2;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h11;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b10 || mem_addr !== 32'hFFFF_FFFC || mem_wdata !== 32'h11) begin errors++; $display("FAIL t2_w0 got we=%b a=%h d=%h exp 10 fffffffc 11", mem_we, mem_addr, mem_wdata); end
    tick();
    checks++; if (mem_we !== 2'b00 || wr_ready !== 1'b1) begin errors++; $display("FAIL t2_gap0 got we=%b wr_ready=%b exp 00 1", mem_we, wr_ready); end
    tick();
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0) begin errors++; $display("FAIL t2_gap1 got we=%b done=%b exp 00 0", mem_we, load_done); end
    wr_valid = 1'b1; wr_data = 32'h22;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b10 || mem_addr !== 32'h0 || mem_wdata !== 32'h22 || load_done !== 1'b1) begin errors++; $display("FAIL t2_w1 got we=%b a=%h d=%h done=%b exp 10 0 22 1", mem_we, mem_addr, mem_wdata, load_done); end
    tick();
  endtask

  task automatic test_zero_len;
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h100; cmd_len = 16'd0;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hDEAD;
    #1;
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL t3_done got we=%b done=%b wr_ready=%b exp 00 1 0", mem_we, load_done, wr_ready); end
    tick();
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL t3_after got we=%b done=%b cmd_ready=%b exp 00 0 1", mem_we, load_done, cmd_ready); end
    wr_valid = 1'b0;
  endtask

  task automatic test_bad_sel;
    cmd_valid = 1'b1; cmd_sel = 2'd2; cmd_base = 32'h200; cmd_len = 16'd1;
    tick();
    cmd_valid = 1'b0;
    checks++; if (load_err !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL t4_err_set got err=%b wr_ready=%b exp 1 1", load_err, wr_ready); end
    wr_valid = 1'b1; wr_data = 32'h77;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t4_consume got we=%b done=%b busy=%b exp 00 1 0", mem_we, load_done, busy); end
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h10; cmd_len = 16'd1;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h99;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h10 || mem_wdata !== 32'h99) begin errors++; $display("FAIL t4_good got we=%b a=%h d=%h exp 01 10 99", mem_we, mem_addr, mem_wdata); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL t4_sticky got err=%b exp 1", load_err); end
    tick();
  endtask

  task automatic test_run_halt;
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (cpu_reset !== 1'b0 || cmd_ready !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL t5_run got cpu_reset=%b cmd=%b wr=%b exp 0 0 0", cpu_reset, cmd_ready, wr_ready); end
    cpu_mem_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h5;
    #1;
    checks++; if (mem_we !== 2'b10 || mem_addr !== 32'h40 || mem_wdata !== 32'h5) begin errors++; $display("FAIL t5_pass got we=%b a=%h d=%h exp 10 40 5", mem_we, mem_addr, mem_wdata); end
    cpu_mem_we = 1'b0; cpu_addr = 32'h44; cpu_wdata = 32'h6;
    #1;
    checks++; if (mem_we !== 2'b00 || mem_addr !== 32'h44 || mem_wdata !== 32'h6) begin errors++; $display("FAIL t5_pass_nowe got we=%b a=%h d=%h exp 00 44 6", mem_we, mem_addr, mem_wdata); end
    run = 1'b1; halt = 1'b1;
    tick();
    run = 1'b0; halt = 1'b0;
    checks++; if (cpu_reset !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_halt got cpu_reset=%b cmd=%b busy=%b exp 1 1 0", cpu_reset, cmd_ready, busy); end
    checks++; if (mem_we !== 2'b00) begin errors++; $display("FAIL t5_halt_we got we=%b exp 00", mem_we); end
  endtask

  task automatic test_cmd_beats_run;
    cmd_valid = 1'b1; run = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h80; cmd_len = 16'd1;
    tick();
    cmd_valid = 1'b0; run = 1'b0;
    checks++; if (busy !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL t5b_cmd_wins got busy=%b cpu_reset=%b exp 1 1", busy, cpu_reset); end
    wr_valid = 1'b1; wr_data = 32'h3C;
    tick();
    wr_valid = 1'b0;
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h80 || cpu_reset !== 1'b1) begin errors++; $display("FAIL t5b_write got we=%b a=%h cpu_reset=%b exp 01 80 1", mem_we, mem_addr, cpu_reset); end
    tick();
    checks++; if (cpu_reset !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL t5b_idle got cpu_reset=%b cmd=%b exp 1 1", cpu_reset, cmd_ready); end
  endtask

  task automatic test_reset_abort;
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_base = 32'h300; cmd_len = 16'd4;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hD1;
    tick();
    checks++; if (mem_we !== 2'b01 || mem_addr !== 32'h300 || mem_wdata !== 32'hD1) begin errors++; $display("FAIL t6_w0 got we=%b a=%h d=%h exp 01 300 d1", mem_we, mem_addr, mem_wdata); end
    wr_data = 32'hD2;
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t6_in_rst got we=%b done=%b cpu_reset=%b busy=%b exp 00 0 1 0", mem_we, load_done, cpu_reset, busy); end
    tick();
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0) begin errors++; $display("FAIL t6_rst_hold got we=%b done=%b exp 00 0", mem_we, load_done); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || load_err !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL t6_release got cmd=%b wr=%b err=%b cpu_reset=%b exp 1 0 0 1", cmd_ready, wr_ready, load_err, cpu_reset); end
    tick();
    checks++; if (mem_we !== 2'b00 || load_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_no_resume got we=%b done=%b busy=%b exp 00 0 0", mem_we, load_done, busy); end
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    run = 1'b0; halt = 1'b0;
    cpu_mem_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_load_imem();
    test_gapped_wrap();
    test_zero_len();
    test_bad_sel();
    test_run_halt();
    test_cmd_beats_run();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Parametrised external-load controller for the CPU test harness. Generalises the reset-time external write mux to NUM_MEM target memories.
- Host issues load commands (memory select, base address, word count) and then streams words with a valid/ready handshake. The block writes them at auto-incremented addresses.
- The CPU is held in reset until the host requests run. During run, CPU store traffic passes through to the data memory.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 32, byte address width
NUM_MEM, 2, number of target memories (index 0 = instruction, 1 = data)
SEL_W, 1, width of memory select (>= clog2(NUM_MEM))
LEN_W, 16, width of word-count field
ADDR_STEP, 4, byte increment per word
DMEM_IDX, 1, memory index driven by CPU stores in RUN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
cmd_valid  in  1  load command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_sel  in  SEL_W  target memory
cmd_base  in  ADDR_W  first byte address
cmd_len  in  LEN_W  word count
wr_valid  in  1  data word valid
wr_ready  out  1  data word accepted when valid&ready
wr_data  in  DATA_W  data word
run  in  1  request CPU release (level, sampled in IDLE)
halt  in  1  request CPU hold (level, sampled in RUN)
cpu_reset  out  1  active-high reset to riscv_cpu
cpu_mem_we  in  1  CPU store enable
cpu_addr  in  ADDR_W  CPU data address
cpu_wdata  in  DATA_W  CPU store data
mem_we  out  NUM_MEM  per-memory write enable
mem_addr  out  ADDR_W  shared write address
mem_wdata  out  DATA_W  shared write data
load_done  out  1  one-cycle pulse at end of each command
load_err  out  1  sticky: command with cmd_sel >= NUM_MEM
busy  out  1  high in LOAD

Behaviour:
- Reset values while reset=0:
  - State IDLE.
  - Registered mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, load_done=0, load_err=0, counters=0.
  - Handshakes are ignored while reset=0.
- States: IDLE, LOAD, RUN.
  - cmd_ready = (state==IDLE).
  - wr_ready = (state==LOAD) and words remaining > 0.
- IDLE:
  - cpu_reset=1, mem_we=0.
  - cmd handshake: latch sel/base/len, set addr_ptr=base and remaining=len, go to LOAD.
  - Else if run=1: go to RUN. cpu_reset falls on the same edge.
  - cmd_valid and run in the same cycle: command wins, and run must still be high on a later IDLE cycle to take effect.
- LOAD:
  - Each wr handshake in cycle n produces, in cycle n+1: mem_we[sel]=1, mem_addr=addr_ptr, mem_wdata=wr_data. Then addr_ptr += ADDR_STEP (mod 2^ADDR_W, wraps silently) and remaining -= 1.
  - Write enable is high for exactly one cycle per accepted word. Back-to-back words give consecutive-cycle writes.
  - After the last word is accepted, load_done pulses in the same cycle as the final mem_we, and state returns to IDLE that cycle.
  - cmd_len=0: command accepted, no writes, load_done pulses the cycle after acceptance, IDLE.
  - cmd_sel >= NUM_MEM: command accepted, words consumed normally, all mem_we remain 0, load_err set (sticky until reset).
  - run and halt are ignored in LOAD.
- RUN:
  - cpu_reset=0. Outputs are combinational passthrough: mem_we[DMEM_IDX]=cpu_mem_we, other bits 0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cmd_ready=0 and wr_ready=0.
  - halt=1: go to IDLE and cpu_reset=1 from the next edge. halt wins over run.
- Reset asserted mid-LOAD aborts the command immediately:
  - No further writes and no load_done pulse.
  - Remaining words are not consumed after reset releases.
- busy = (state==LOAD).

Test Plan:
1. Reset release; cmd sel=0 base=0x0 len=3; words 0xA1,0xB2,0xC3 back-to-back -> mem_we=01 on three consecutive cycles at addr 0x0,0x4,0x8 with those data; load_done pulses with the third write; cpu_reset stays 1.
2. cmd sel=1 base=0xFFFFFFFC len=2; words 0x11,0x22 with wr_valid gapped by 2 idle cycles -> writes to data memory at 0xFFFFFFFC then 0x00000000; no writes in gap cycles.
3. cmd len=0 -> no mem_we; load_done one cycle after accept; cmd_ready=1 the following cycle.
4. cmd sel=2 (NUM_MEM=2) len=1, one word -> mem_we stays 00; load_err=1 and remains 1 through a subsequent valid load.
5. run=1 in IDLE -> cpu_reset=0 next cycle; cpu_mem_we=1 cpu_addr=0x40 cpu_wdata=0x5 -> mem_we=10, addr 0x40, data 0x5 same cycle; run=halt=1 -> cpu_reset=1 next edge, state IDLE.
6. Reset pulsed low after 1 of 4 words accepted -> only one write issued, no load_done; after release cmd_ready=1, load_err=0, cpu_reset=1.
